mu0_fetch_control: RTL

Sequencing stage for the MU0 datapath. It holds PC and IR and runs the fetch/execute/halt state machine. It drives the 12-bit address-select mux (PC vs IR operand) and memory read/write strobes, and issues accumulator-load/ALU controls. It sits directly upstream of the address multiplexer and memory, and consumes memory data and accumulator flags.

---
 rtl/mu0_pkg.sv | 32 +++
 rtl/mu0_fetch_control_mux12.sv | 11 +
 rtl/mu0_fetch_control.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 sequencing stage: opcodes, FSM states and ALU controls.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Only the accumulator-loading opcodes give a meaningful ALU operation.
  function automatic logic [1:0] alu_op_for(input logic [3:0] op);
    logic [1:0] res;
    res = ALU_PASS_B;
    if (op == OP_ADD) res = ALU_ADD;
    else if (op == OP_SUB) res = ALU_SUB;
    return res;
  endfunction

endpackage

// File: rtl/mu0_fetch_control_mux12.sv
// 12-bit two-way address-select multiplexer (A when S=0, B when S=1).
module MU0_Mux12 (
  input  logic [11:0] A,
  input  logic [11:0] B,
  input  logic        S,
  output logic [11:0] Q
);

  assign Q = S ? B : A;

endmodule

// File: rtl/mu0_fetch_control.sv
// MU0 sequencer: holds PC/IR and runs the fetch/execute/halt state machine
// driving the address mux, memory strobes and accumulator controls.
module mu0_fetch_control
  import mu0_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Din,
  input  logic        MemReady,
  input  logic        N,
  input  logic        Z,
  output logic [11:0] Address,
  output logic        AddrSel,
  output logic [11:0] PC,
  output logic [15:0] IR,
  output logic        Rd,
  output logic        Wr,
  output logic        AccEn,
  output logic [1:0]  AluOp,
  output logic        Fetch,
  output logic        Halted
);

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        addr_sel, rd, wr, acc_en;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_sel = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    acc_en   = 1'b0;
    alu_op   = ALU_PASS_B;
    unique case (state_q)
      S_FETCH: begin
        rd = 1'b1;
        if (MemReady) begin
          ir_d    = Din;
          pc_d    = pc_q + 12'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            addr_sel = 1'b1;
            rd       = 1'b1;
            alu_op   = alu_op_for(opcode);
            acc_en   = MemReady;
            if (MemReady) state_d = S_FETCH;
          end
          OP_STA: begin
            addr_sel = 1'b1;
            wr       = 1'b1;
            if (MemReady) state_d = S_FETCH;
          end
          // Jumps never touch memory, so MemReady is irrelevant here.
          OP_JMP: begin
            addr_sel = 1'b1;
            pc_d     = ir_q[11:0];
            state_d  = S_FETCH;
          end
          OP_JGE: begin
            addr_sel = 1'b1;
            if (!N) pc_d = ir_q[11:0];
            state_d  = S_FETCH;
          end
          OP_JNE: begin
            addr_sel = 1'b1;
            if (!Z) pc_d = ir_q[11:0];
            state_d  = S_FETCH;
          end
          OP_STP:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  MU0_Mux12 u_addr_mux (
    .A (pc_q),
    .B (ir_q[11:0]),
    .S (addr_sel),
    .Q (Address)
  );

  // Strobes are gated by Reset so they drop without waiting for a clock edge.
  assign Rd      = rd & ~Reset;
  assign Wr      = wr & ~Reset;
  assign AccEn   = acc_en & ~Reset;
  assign AddrSel = addr_sel;
  assign AluOp   = alu_op;
  assign PC      = pc_q;
  assign IR      = ir_q;
  assign Fetch   = (state_q == S_FETCH);
  assign Halted  = (state_q == S_HALT);

endmodule
